// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } sa_state_t;

  // Bit-counter width: enough to count 0..width-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  // The adder controller itself.
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );

endinterface

// File: rtl/dataflow_adder.sv
// Single-bit full adder shared by every bit position of the serial add.
module dataflow_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder stepped LSB-first over WIDTH
// cycles, with valid/ready handshakes for operands and results.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  sa_state_t        state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_next;
  logic             last_bit;

  dataflow_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  // Next sum shift-register value: new bit enters at the MSB. Built as a
  // shift-then-overwrite so WIDTH=1 needs no zero-width slice.
  always_comb begin
    sum_next            = sum_sr >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Controller FSM with counter, shift registers and registered result/status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr       <= bus.a;
            b_sr       <= bus.b;
            carry      <= bus.c_in;
            cnt        <= '0;
            state      <= ADD;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= fa_c;
          if (last_bit) begin
            sum_q       <= sum_next;
            c_out_q     <= fa_c;
            ovf_q       <= carry ^ fa_c;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector and random bench for serial_add_ctrl at WIDTH 8, 1 and 16.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8))  bus8  ();
  serial_add_ctrl_if #(.WIDTH(1))  bus1  ();
  serial_add_ctrl_if #(.WIDTH(16)) bus16 ();

  serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  serial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns {ovf, c_out, sum[15:0]} for a w-bit add.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic ci);
    logic [16:0] full;
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic [16:0] mask;
    mask = (17'd1 << w) - 17'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, ci};
    s    = full[15:0] & mask[15:0];
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // Presents one operand set to the 8-bit DUT (assumed IDLE) and waits for DONE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, output int lat);
    bus8.a = a; bus8.b = b; bus8.c_in = ci; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.c_in = 1'($urandom);
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release8();
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic op1(input logic a, input logic b, input logic ci, output logic [2:0] res);
    int n;
    bus1.a = a; bus1.b = b; bus1.c_in = ci; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    res = {bus1.out_valid, bus1.ovf, bus1.c_out} ^ {1'b0, 2'b00} ;
    res = {bus1.ovf, bus1.c_out, bus1.sum[0]};
    check("w1_valid", {31'd0, bus1.out_valid}, 32'd1);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      output logic [18:0] res);
    int n;
    bus16.a = a; bus16.b = b; bus16.c_in = ci; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    n = 0;
    while (!bus16.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    res = {bus16.out_valid, bus16.ovf, bus16.c_out, bus16.sum};
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [17:0] exp;
    logic [2:0]  r1;
    logic [18:0] r16;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] wa;
    logic [15:0] wb;
    logic        rc;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};

    bus8.in_valid = 0;  bus8.out_ready = 0;  bus8.a = '0;  bus8.b = '0;  bus8.c_in = 0;
    bus1.in_valid = 0;  bus1.out_ready = 0;  bus1.a = '0;  bus1.b = '0;  bus1.c_in = 0;
    bus16.in_valid = 0; bus16.out_ready = 0; bus16.a = '0; bus16.b = '0; bus16.c_in = 0;

    // Reset state
    #12;
    check("rst_in_ready",  {31'd0, bus8.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    check("rst_busy",      {31'd0, bus8.busy}, 32'd0);
    check("rst_result",    {22'd0, bus8.ovf, bus8.c_out, bus8.sum}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      check("vec_in_ready", {31'd0, bus8.in_ready}, 32'd1);
      op8(vecs[i].a, vecs[i].b, vecs[i].ci, lat);
      check("vec_latency", lat, 32'd8);
      check("vec_result", {22'd0, bus8.ovf, bus8.c_out, bus8.sum},
            {22'd0, vecs[i].ovf, vecs[i].cout, vecs[i].sum});
      check("vec_exclusive", {30'd0, bus8.out_valid, bus8.in_ready}, 32'd2);
      check("vec_busy", {31'd0, bus8.busy}, 32'd1);
      release8();
      check("vec_idle", {29'd0, bus8.in_ready, bus8.out_valid, bus8.busy}, 32'd4);
      check("vec_hold", {24'd0, bus8.sum}, {24'd0, vecs[i].sum});
    end

    // Backpressure in DONE, with operand inputs wiggling
    op8(8'h7F, 8'h00, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = ~bus8.in_valid;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.c_in = 1'($urandom);
      @(posedge clk); #1;
      check("bp_state", {30'd0, bus8.out_valid, bus8.in_ready}, 32'd2);
      check("bp_result", {22'd0, bus8.ovf, bus8.c_out, bus8.sum}, {22'd0, 2'b10, 8'h80});
    end
    bus8.in_valid = 1'b0;
    release8();
    check("bp_release", {29'd0, bus8.in_ready, bus8.out_valid, bus8.busy}, 32'd4);

    // Reset during the third ADD cycle
    bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.c_in = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_before", {31'd0, bus8.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_status", {29'd0, bus8.in_ready, bus8.out_valid, bus8.busy}, 32'd4);
    check("mid_rst_sum", {24'd0, bus8.sum}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'h01, 8'h01, 1'b0, lat);
    check("post_rst_lat", lat, 32'd8);
    check("post_rst_result", {22'd0, bus8.ovf, bus8.c_out, bus8.sum}, {22'd0, 2'b00, 8'h02});
    release8();

    // Random back-to-back ops, WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = ref_add(8, {8'd0, ra}, {8'd0, rb}, rc);
      op8(ra, rb, rc, lat);
      check("rnd8", {21'd0, bus8.out_valid, bus8.ovf, bus8.c_out, bus8.sum},
            {21'd0, 1'b1, exp[17], exp[16], exp[7:0]});
      release8();
    end

    // WIDTH=1: exhaustive, twice
    for (int i = 0; i < 16; i++) begin
      wa = 16'(i[0]); wb = 16'(i[1]); rc = i[2];
      exp = ref_add(1, wa, wb, rc);
      op1(wa[0], wb[0], rc, r1);
      check("rnd1", {29'd0, r1}, {29'd0, exp[17], exp[16], exp[0]});
    end

    // Random ops, WIDTH=16
    for (int i = 0; i < 200; i++) begin
      wa = 16'($urandom); wb = 16'($urandom); rc = 1'($urandom);
      if (i == 0) begin wa = 16'h7FFF; wb = 16'h0000; rc = 1'b1; end
      if (i == 1) begin wa = 16'hFFFF; wb = 16'h0001; rc = 1'b0; end
      exp = ref_add(16, wa, wb, rc);
      op16(wa, wb, rc, r16);
      check("rnd16", {13'd0, r16}, {13'd0, 1'b1, exp});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
